// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// ex_muldiv_if : EX-stage mul/div request/response bundle.
// Revision: 1.0
// ============================================================================
interface ex_muldiv_if;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        flush;
   logic        stall_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        busy_o;

   modport master (
      output start, md_op, srca, srcb, flush,
      input  stall_o, hi_o, lo_o, busy_o
   );

   modport slave (
      input  start, md_op, srca, srcb, flush,
      output stall_o, hi_o, lo_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// ex_muldiv : EX-stage multiply / restoring-divide unit owning HI and LO.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
// Revision: 1.0
// ============================================================================
module ex_muldiv (
   input  logic       clk,
   input  logic       rst,
   ex_muldiv_if.slave bus
);

   localparam logic [3:0] c_OP_MULT  = 4'd1;
   localparam logic [3:0] c_OP_MULTU = 4'd2;
   localparam logic [3:0] c_OP_DIV   = 4'd3;
   localparam logic [3:0] c_OP_DIVU  = 4'd4;
   localparam logic [3:0] c_OP_MTHI  = 4'd5;
   localparam logic [3:0] c_OP_MTLO  = 4'd6;
   localparam logic [3:0] c_OP_MADD  = 4'd7;
   localparam logic [3:0] c_OP_MADDU = 4'd8;
   localparam logic [3:0] c_OP_MSUB  = 4'd9;
   localparam logic [3:0] c_OP_MSUBU = 4'd10;

`ifdef MULDIV_MADD_EN
   localparam logic c_MADD_EN = 1'b1;
`else
   localparam logic c_MADD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   logic [3:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [5:0]  r_cnt;
   logic [31:0] r_rem;
   logic [31:0] r_quot;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_idle;
   logic        w_in_mul;
   logic        w_in_div;
   logic        w_mul_signed;
   logic [63:0] w_a64;
   logic [63:0] w_b64;
   logic [63:0] w_prod;
   logic [63:0] w_mul_res;
   logic        w_div_signed;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic        w_first;
   logic [31:0] w_qsrc;
   logic [31:0] w_rsrc;
   logic [32:0] w_trial;
   logic [32:0] w_diff;
   logic        w_ge;
   logic [31:0] w_rem_nx;
   logic [31:0] w_quot_nx;
   logic [31:0] w_q_fin;
   logic [31:0] w_r_fin;

   // Accumulate ops are only recognised when the feature is built in.
   always_comb begin
      w_in_mul = (bus.md_op == c_OP_MULT) || (bus.md_op == c_OP_MULTU);
      if (c_MADD_EN && (bus.md_op >= c_OP_MADD) && (bus.md_op <= c_OP_MSUBU))
         w_in_mul = 1'b1;
      w_in_div = (bus.md_op == c_OP_DIV) || (bus.md_op == c_OP_DIVU);
   end

   assign w_idle      = (r_state == S_IDLE);
   assign bus.stall_o = (w_idle && bus.start && (w_in_mul || w_in_div))
                        || (r_state == S_MUL) || (r_state == S_DIV);
   assign bus.busy_o  = !w_idle;
   assign bus.hi_o    = r_hi;
   assign bus.lo_o    = r_lo;

   assign w_mul_signed = (r_op == c_OP_MULT) || (r_op == c_OP_MADD) || (r_op == c_OP_MSUB);
   assign w_a64  = w_mul_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
   assign w_b64  = w_mul_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
   assign w_prod = w_a64 * w_b64;

   always_comb begin
      w_mul_res = w_prod;
      case (r_op)
         c_OP_MADD, c_OP_MADDU: w_mul_res = {r_hi, r_lo} + w_prod;
         c_OP_MSUB, c_OP_MSUBU: w_mul_res = {r_hi, r_lo} - w_prod;
         default:               w_mul_res = w_prod;
      endcase
   end

   // Restoring divide on magnitudes; the first iteration seeds from the latched dividend.
   assign w_div_signed = (r_op == c_OP_DIV);
   assign w_mag_a   = (w_div_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
   assign w_mag_b   = (w_div_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
   assign w_first   = (r_cnt == 6'd0);
   assign w_qsrc    = w_first ? w_mag_a : r_quot;
   assign w_rsrc    = w_first ? 32'd0 : r_rem;
   assign w_trial   = {w_rsrc, w_qsrc[31]};
   assign w_diff    = w_trial - {1'b0, w_mag_b};
   assign w_ge      = ~w_diff[32];
   assign w_rem_nx  = w_ge ? w_diff[31:0] : w_trial[31:0];
   assign w_quot_nx = {w_qsrc[30:0], w_ge};
   assign w_q_fin   = (w_div_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - w_quot_nx) : w_quot_nx;
   assign w_r_fin   = (w_div_signed && r_a[31]) ? (32'd0 - w_rem_nx) : w_rem_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= 4'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_cnt   <= 6'd0;
         r_rem   <= 32'd0;
         r_quot  <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else if (bus.flush) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (w_in_mul || w_in_div) begin
                     r_op    <= bus.md_op;
                     r_a     <= bus.srca;
                     r_b     <= bus.srcb;
                     r_cnt   <= 6'd0;
                     r_state <= w_in_mul ? S_MUL : S_DIV;
                  end else if (bus.md_op == c_OP_MTHI) begin
                     r_hi <= bus.srca;
                  end else if (bus.md_op == c_OP_MTLO) begin
                     r_lo <= bus.srca;
                  end
               end
            end
            S_MUL: begin
               {r_hi, r_lo} <= w_mul_res;
               r_state      <= S_DONE;
            end
            S_DIV: begin
               r_rem  <= w_rem_nx;
               r_quot <= w_quot_nx;
               r_cnt  <= r_cnt + 6'd1;
               if (r_cnt == 6'd31) begin
                  r_state <= S_DONE;
                  // A zero divisor still runs the full sequence but leaves HI/LO alone.
                  if (r_b != 32'd0) begin
                     r_hi <= w_r_fin;
                     r_lo <= w_q_fin;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// tb_ex_muldiv : randomized self-checking bench for ex_muldiv.
// Revision: 1.0
// ============================================================================
module tb_ex_muldiv;

`ifdef MULDIV_MADD_EN
   localparam bit c_MADD_EN = 1'b1;
`else
   localparam bit c_MADD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ex_muldiv_if u_if ();
   ex_muldiv u_dut (.clk(clk), .rst(rst), .bus(u_if));

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi     = 32'd0;
   logic [31:0] m_lo     = 32'd0;

   // Issue one op, hold start while stalled and through DONE, then release.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     acc, prod;
      logic [31:0]     e_hi, e_lo;
      int              ex_st, n;
      sa = $signed(a); sb = $signed(b);
      ua = {32'd0, a}; ub = {32'd0, b};
      e_hi = m_hi; e_lo = m_lo; ex_st = 0;
      acc = {m_hi, m_lo};
      case (op)
         4'd1: begin prod = sa * sb; {e_hi, e_lo} = prod; ex_st = 2; end
         4'd2: begin prod = ua * ub; {e_hi, e_lo} = prod; ex_st = 2; end
         4'd3: begin
            ex_st = 33;
            if (b != 32'd0) begin e_lo = 32'(sa / sb); e_hi = 32'(sa % sb); end
         end
         4'd4: begin
            ex_st = 33;
            if (b != 32'd0) begin e_lo = 32'(ua / ub); e_hi = 32'(ua % ub); end
         end
         4'd5: e_hi = a;
         4'd6: e_lo = a;
         4'd7, 4'd8, 4'd9, 4'd10: begin
            if (c_MADD_EN) begin
               ex_st = 2;
               prod = (op == 4'd7 || op == 4'd9) ? 64'(sa * sb) : 64'(ua * ub);
               {e_hi, e_lo} = (op <= 4'd8) ? acc + prod : acc - prod;
            end
         end
         default: ;
      endcase

      @(posedge clk); #1;
      u_if.start = 1'b1; u_if.md_op = op; u_if.srca = a; u_if.srcb = b;
      #1;
      n = 0;
      while (u_if.stall_o === 1'b1 && n < 40) begin
         n++;
         @(posedge clk); #2;
      end
      n_checks++;
      if (n != ex_st) begin
         n_fail++;
         $display("FAIL stall_cycles op=%0d a=%h b=%h: got %0d expected %0d", op, a, b, n, ex_st);
      end
      if (ex_st > 0) begin
         n_checks += 3;
         if (u_if.busy_o !== 1'b1) begin
            n_fail++; $display("FAIL done_busy op=%0d: got %b expected 1", op, u_if.busy_o);
         end
         if (u_if.hi_o !== e_hi) begin
            n_fail++; $display("FAIL done_hi op=%0d a=%h b=%h: got %h expected %h", op, a, b, u_if.hi_o, e_hi);
         end
         if (u_if.lo_o !== e_lo) begin
            n_fail++; $display("FAIL done_lo op=%0d a=%h b=%h: got %h expected %h", op, a, b, u_if.lo_o, e_lo);
         end
      end
      @(posedge clk); #1;
      u_if.start = 1'b0; u_if.md_op = 4'd0;
      #1;
      n_checks += 4;
      if (u_if.hi_o !== e_hi) begin
         n_fail++; $display("FAIL after_hi op=%0d a=%h b=%h: got %h expected %h", op, a, b, u_if.hi_o, e_hi);
      end
      if (u_if.lo_o !== e_lo) begin
         n_fail++; $display("FAIL after_lo op=%0d a=%h b=%h: got %h expected %h", op, a, b, u_if.lo_o, e_lo);
      end
      if (u_if.busy_o !== 1'b0) begin
         n_fail++; $display("FAIL after_busy op=%0d: got %b expected 0", op, u_if.busy_o);
      end
      if (u_if.stall_o !== 1'b0) begin
         n_fail++; $display("FAIL after_stall op=%0d: got %b expected 0", op, u_if.stall_o);
      end
      m_hi = e_hi; m_lo = e_lo;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks += 4;
      if (u_if.hi_o !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", u_if.hi_o); end
      if (u_if.lo_o !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", u_if.lo_o); end
      if (u_if.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", u_if.stall_o); end
      if (u_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", u_if.busy_o); end
      rst = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
   endtask

   task automatic test_mult();
      do_op(4'd1, 32'hFFFFFFFE, 32'h00000003);
      n_checks += 2;
      if (u_if.hi_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", u_if.hi_o); end
      if (u_if.lo_o !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffa", u_if.lo_o); end
      do_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
   endtask

   task automatic test_div();
      do_op(4'd3, 32'hFFFFFFF9, 32'h00000002);
      n_checks += 2;
      if (u_if.lo_o !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", u_if.lo_o); end
      if (u_if.hi_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", u_if.hi_o); end
      do_op(4'd4, 32'd7, 32'd0);
      do_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
      do_op(4'd3, 32'd7, 32'hFFFFFFFE);
   endtask

   task automatic test_mtlo_mthi();
      @(posedge clk); #1;
      u_if.start = 1'b1; u_if.md_op = 4'd6; u_if.srca = 32'h12345678; u_if.srcb = $urandom;
      #1;
      n_checks++;
      if (u_if.stall_o !== 1'b0) begin n_fail++; $display("FAIL mtlo_stall: got %b expected 0", u_if.stall_o); end
      @(posedge clk); #1;
      u_if.md_op = 4'd5; u_if.srca = 32'hCAFEF00D;
      #1;
      n_checks += 3;
      if (u_if.stall_o !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b expected 0", u_if.stall_o); end
      if (u_if.lo_o !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 12345678", u_if.lo_o); end
      if (u_if.hi_o !== m_hi) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h expected %h", u_if.hi_o, m_hi); end
      @(posedge clk); #1;
      u_if.start = 1'b0; u_if.md_op = 4'd0;
      #1;
      n_checks += 2;
      if (u_if.hi_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mthi_hi: got %h expected cafef00d", u_if.hi_o); end
      if (u_if.stall_o !== 1'b0) begin n_fail++; $display("FAIL mthi_idle_stall: got %b expected 0", u_if.stall_o); end
      m_hi = 32'hCAFEF00D; m_lo = 32'h12345678;
   endtask

   // Flush `at` cycles after the accept cycle; no HI/LO write may survive.
   task automatic test_flush(input logic [3:0] op, input int at);
      @(posedge clk); #1;
      u_if.start = 1'b1; u_if.md_op = op; u_if.srca = $urandom; u_if.srcb = $urandom | 32'd1;
      repeat (at) @(posedge clk);
      #1;
      u_if.flush = 1'b1;
      @(posedge clk); #1;
      u_if.flush = 1'b0; u_if.start = 1'b0; u_if.md_op = 4'd0;
      #1;
      n_checks += 4;
      if (u_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy op=%0d at=%0d: got %b expected 0", op, at, u_if.busy_o); end
      if (u_if.stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall op=%0d at=%0d: got %b expected 0", op, at, u_if.stall_o); end
      if (u_if.hi_o !== m_hi) begin n_fail++; $display("FAIL flush_hi op=%0d at=%0d: got %h expected %h", op, at, u_if.hi_o, m_hi); end
      if (u_if.lo_o !== m_lo) begin n_fail++; $display("FAIL flush_lo op=%0d at=%0d: got %h expected %h", op, at, u_if.lo_o, m_lo); end
      @(posedge clk); #2;
      n_checks += 2;
      if (u_if.hi_o !== m_hi) begin n_fail++; $display("FAIL flush_hi_late op=%0d: got %h expected %h", op, u_if.hi_o, m_hi); end
      if (u_if.lo_o !== m_lo) begin n_fail++; $display("FAIL flush_lo_late op=%0d: got %h expected %h", op, u_if.lo_o, m_lo); end
   endtask

   task automatic test_flush_start();
      @(posedge clk); #1;
      u_if.start = 1'b1; u_if.md_op = 4'd5; u_if.srca = ~m_hi; u_if.flush = 1'b1;
      @(posedge clk); #1;
      u_if.md_op = 4'd3; u_if.srca = $urandom; u_if.srcb = 32'd3;
      #1;
      n_checks++;
      if (u_if.hi_o !== m_hi) begin n_fail++; $display("FAIL flush_mthi_hi: got %h expected %h", u_if.hi_o, m_hi); end
      @(posedge clk); #1;
      u_if.start = 1'b0; u_if.flush = 1'b0; u_if.md_op = 4'd0;
      #1;
      n_checks++;
      if (u_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b expected 0", u_if.busy_o); end
   endtask

   task automatic test_madd();
      logic [31:0] e_hi, e_lo;
      do_op(4'd5, 32'd0, 32'd0);
      do_op(4'd6, 32'hFFFFFFFF, 32'd0);
      do_op(4'd8, 32'd1, 32'd1);
`ifdef MULDIV_MADD_EN
      e_hi = 32'd1; e_lo = 32'd0;
`else
      e_hi = 32'd0; e_lo = 32'hFFFFFFFF;
`endif
      n_checks += 2;
      if (u_if.hi_o !== e_hi) begin n_fail++; $display("FAIL maddu_hi: got %h expected %h", u_if.hi_o, e_hi); end
      if (u_if.lo_o !== e_lo) begin n_fail++; $display("FAIL maddu_lo: got %h expected %h", u_if.lo_o, e_lo); end
      do_op(4'd7, 32'hFFFFFFFF, 32'd5);
      do_op(4'd9, 32'h00001000, 32'h80000000);
      do_op(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);
   endtask

   task automatic test_undefined();
      logic [3:0] ops [6] = '{4'd0, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
      for (int i = 0; i < 6; i++) do_op(ops[i], $urandom, $urandom);
   endtask

   task automatic test_rst_div();
      do_op(4'd5, 32'hA5A5A5A5, 32'd0);
      @(posedge clk); #1;
      u_if.start = 1'b1; u_if.md_op = 4'd3; u_if.srca = $urandom; u_if.srcb = 32'd5;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1; u_if.flush = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; u_if.flush = 1'b0; u_if.start = 1'b0; u_if.md_op = 4'd0;
      #1;
      n_checks += 4;
      if (u_if.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_div_busy: got %b expected 0", u_if.busy_o); end
      if (u_if.stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_div_stall: got %b expected 0", u_if.stall_o); end
      if (u_if.hi_o !== 32'd0) begin n_fail++; $display("FAIL rst_div_hi: got %h expected 0", u_if.hi_o); end
      if (u_if.lo_o !== 32'd0) begin n_fail++; $display("FAIL rst_div_lo: got %h expected 0", u_if.lo_o); end
      m_hi = 32'd0; m_lo = 32'd0;
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h80000000;
            2: b = 32'hFFFFFFFF;
            3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            4: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         do_op(op, a, b);
      end
   endtask

   initial begin
      u_if.start = 1'b0; u_if.md_op = 4'd0; u_if.srca = 32'd0; u_if.srcb = 32'd0; u_if.flush = 1'b0;
      test_reset();
      test_mult();
      test_div();
      test_mtlo_mthi();
      test_flush(4'd3, 10);
      test_flush(4'd4, 32);
      test_flush(4'd1, 1);
      test_flush_start();
      test_madd();
      test_undefined();
      test_rst_div();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
